jtopl_wr_sched: RTL and testbench

JTOPL_WR_SCHED -- requirements
Module: jtopl_wr_sched

---
 rtl/jtopl_wr_sched_pkg.sv | 34 +++
 rtl/jtopl_slot_dec.sv | 17 +
 rtl/jtopl_wr_sched.sv | 147 ++++++++++++++
 tb/tb_jtopl_wr_sched.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtopl_wr_sched_pkg.sv
// Shared definitions for the operator register write scheduler:
// field codes, slot count, FSM states and a modular slot-offset helper.
package jtopl_wr_sched_pkg;

    localparam int SLOTS = 18;

    localparam logic [2:0] FLD_MULT   = 3'b001;
    localparam logic [2:0] FLD_KSL_TL = 3'b010;
    localparam logic [2:0] FLD_AR_DR  = 3'b011;
    localparam logic [2:0] FLD_SL_RR  = 3'b100;
    localparam logic [2:0] FLD_WAV    = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    // Adds a fixed offset to an operator slot, wrapping modulo the slot count.
    function automatic logic [4:0] slot_add(input logic [4:0] s, input int off);
        logic [5:0] sum;
        sum = {1'b0, s} + 6'(off);
        if (sum >= 6'(SLOTS)) begin
            sum = sum - 6'(SLOTS);
        end
        return sum[4:0];
    endfunction

    // True when the address field code selects an operator register.
    function automatic logic is_op_field(input logic [2:0] f);
        return (f == FLD_MULT) || (f == FLD_KSL_TL) || (f == FLD_AR_DR) ||
               (f == FLD_SL_RR) || (f == FLD_WAV);
    endfunction

endpackage

// File: rtl/jtopl_slot_dec.sv
// Maps the low address bits (row in [4:3], column in [2:0]) to an operator
// slot number and flags offsets that do not correspond to an operator.
module jtopl_slot_dec (
    input  logic [4:0] addr_i,
    output logic       valid_o,
    output logic [4:0] op_slot_o
);

    // Slot = 6*row + column, built from shifts; only rows 0..2 and columns 0..5 exist.
    always_comb begin
        valid_o   = (addr_i[4:3] != 2'd3) && (addr_i[2:0] < 3'd6);
        op_slot_o = {1'b0, addr_i[4:3], 2'b00}
                  + {2'b00, addr_i[4:3], 1'b0}
                  + {2'b00, addr_i[2:0]};
    end

endmodule

// File: rtl/jtopl_wr_sched.sv
// Operator register write scheduler: captures a CPU data write and holds it
// until the slot rotation reaches each of three offset target slots, then
// emits slot-qualified update strobes for the register shift chain.
module jtopl_wr_sched
    import jtopl_wr_sched_pkg::*;
#(
    parameter int OFF_I  = 0,
    parameter int OFF_II = 0,
    parameter int OFF_IV = 0
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    input  logic       wr,
    input  logic       addr,
    input  logic [7:0] din,
    output logic [4:0] slot,
    output logic [7:0] dout,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_wav,
    output logic       update_op_I,
    output logic       update_op_II,
    output logic       update_op_IV,
    output logic       busy,
    output logic       ovf
);

    state_t     state_q, state_d;
    logic [4:0] slot_q;
    logic [7:0] addr_q;
    logic [7:0] dout_q, dout_d;
    logic [2:0] fld_q, fld_d;
    logic [2:0] pend_q, pend_d;
    logic [4:0] tgt_i_q, tgt_i_d;
    logic [4:0] tgt_ii_q, tgt_ii_d;
    logic [4:0] tgt_iv_q, tgt_iv_d;
    logic       ovf_q, ovf_d;
    logic       dec_valid;
    logic [4:0] dec_slot;
    logic       armed;
    logic [2:0] upd;

    jtopl_slot_dec u_slot_dec (
        .addr_i    (addr_q[4:0]),
        .valid_o   (dec_valid),
        .op_slot_o (dec_slot)
    );

    assign armed = (state_q == ST_ARMED);
    assign upd[0] = armed && pend_q[0] && (slot_q == tgt_i_q);
    assign upd[1] = armed && pend_q[1] && (slot_q == tgt_ii_q);
    assign upd[2] = armed && pend_q[2] && (slot_q == tgt_iv_q);

    // Slot rotation advances on every enabled clock and wraps after the last slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= 5'd0;
        end else if (cen) begin
            slot_q <= (slot_q == 5'(SLOTS - 1)) ? 5'd0 : slot_q + 5'd1;
        end
    end

    // Address writes are always taken; a pending write keeps its own decoded copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= 8'd0;
        end else if (wr && !addr) begin
            addr_q <= din;
        end
    end

    // State register for the write FSM and everything captured with an accepted write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dout_q   <= 8'd0;
            fld_q    <= 3'd0;
            pend_q   <= 3'd0;
            tgt_i_q  <= 5'd0;
            tgt_ii_q <= 5'd0;
            tgt_iv_q <= 5'd0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dout_q   <= dout_d;
            fld_q    <= fld_d;
            pend_q   <= pend_d;
            tgt_i_q  <= tgt_i_d;
            tgt_ii_q <= tgt_ii_d;
            tgt_iv_q <= tgt_iv_d;
            ovf_q    <= ovf_d;
        end
    end

    // Retires strobes on enabled edges and accepts or drops incoming data writes.
    always_comb begin
        state_d  = state_q;
        dout_d   = dout_q;
        fld_d    = fld_q;
        pend_d   = pend_q;
        tgt_i_d  = tgt_i_q;
        tgt_ii_d = tgt_ii_q;
        tgt_iv_d = tgt_iv_q;
        ovf_d    = ovf_q;

        if (armed && cen) begin
            pend_d = pend_q & ~upd;
            if (pend_d == 3'd0) begin
                state_d = ST_IDLE;
            end
        end

        if (wr && addr) begin
            if (!armed) begin
                dout_d = din;
                ovf_d  = 1'b0;
                if (is_op_field(addr_q[7:5]) && dec_valid) begin
                    fld_d    = addr_q[7:5];
                    tgt_i_d  = slot_add(dec_slot, OFF_I);
                    tgt_ii_d = slot_add(dec_slot, OFF_II);
                    tgt_iv_d = slot_add(dec_slot, OFF_IV);
                    pend_d   = 3'b111;
                    state_d  = ST_ARMED;
                end
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    assign slot         = slot_q;
    assign dout         = dout_q;
    assign busy         = armed;
    assign ovf          = ovf_q;
    assign update_op_I  = upd[0];
    assign update_op_II = upd[1];
    assign update_op_IV = upd[2];
    assign up_mult      = armed && (fld_q == FLD_MULT);
    assign up_ksl_tl    = armed && (fld_q == FLD_KSL_TL);
    assign up_ar_dr     = armed && (fld_q == FLD_AR_DR);
    assign up_sl_rr     = armed && (fld_q == FLD_SL_RR);
    assign up_wav       = armed && (fld_q == FLD_WAV);

endmodule

// File: tb/tb_jtopl_wr_sched.sv
// Directed bench for the write scheduler: one default-offset instance and one
// with OFF_II=1 / OFF_IV=17 sharing the same CPU-side stimulus.
module tb_jtopl_wr_sched;

    logic       clk;
    logic       rst;
    logic       cen;
    logic       wr;
    logic       addr;
    logic [7:0] din;

    logic [4:0] slot;
    logic [7:0] dout;
    logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav;
    logic       update_op_I, update_op_II, update_op_IV;
    logic       busy, ovf;

    logic [4:0] slot2;
    logic [7:0] dout2;
    logic       up_mult2, up_ksl_tl2, up_ar_dr2, up_sl_rr2, up_wav2;
    logic       update_op_I2, update_op_II2, update_op_IV2;
    logic       busy2, ovf2;

    logic [2:0] stb;
    logic [2:0] stb2;
    logic [4:0] ups;

    int vectors;
    int miscompares;
    int expSlot;

    assign stb  = {update_op_I, update_op_II, update_op_IV};
    assign stb2 = {update_op_I2, update_op_II2, update_op_IV2};
    assign ups  = {up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav};

    jtopl_wr_sched dut (
        .rst          (rst),
        .clk          (clk),
        .cen          (cen),
        .wr           (wr),
        .addr         (addr),
        .din          (din),
        .slot         (slot),
        .dout         (dout),
        .up_mult      (up_mult),
        .up_ksl_tl    (up_ksl_tl),
        .up_ar_dr     (up_ar_dr),
        .up_sl_rr     (up_sl_rr),
        .up_wav       (up_wav),
        .update_op_I  (update_op_I),
        .update_op_II (update_op_II),
        .update_op_IV (update_op_IV),
        .busy         (busy),
        .ovf          (ovf)
    );

    jtopl_wr_sched #(
        .OFF_I  (0),
        .OFF_II (1),
        .OFF_IV (17)
    ) dut2 (
        .rst          (rst),
        .clk          (clk),
        .cen          (cen),
        .wr           (wr),
        .addr         (addr),
        .din          (din),
        .slot         (slot2),
        .dout         (dout2),
        .up_mult      (up_mult2),
        .up_ksl_tl    (up_ksl_tl2),
        .up_ar_dr     (up_ar_dr2),
        .up_sl_rr     (up_sl_rr2),
        .up_wav       (up_wav2),
        .update_op_I  (update_op_I2),
        .update_op_II (update_op_II2),
        .update_op_IV (update_op_IV2),
        .busy         (busy2),
        .ovf          (ovf2)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one clock cycle of inputs from the falling edge, then returns just after the rising edge.
    task automatic applyStimulus(input logic c, input logic w, input logic a, input logic [7:0] d);
        @(negedge clk);
        cen  = c;
        wr   = w;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
        if (c) begin
            expSlot = (expSlot == 17) ? 0 : expSlot + 1;
        end
    endtask

    // Compares one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Directed sequence covering reset, scheduling, drops, overflow and offsets.
    initial begin
        int premature;
        int cntI, cntII, cntIV;
        int slotI, slotII, slotIV;
        logic busyAt1;

        vectors     = 0;
        miscompares = 0;
        expSlot     = 0;
        rst  = 1'b1;
        cen  = 1'b0;
        wr   = 1'b0;
        addr = 1'b0;
        din  = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_slot",  32'(slot), 32'd0);
        checkOutput("reset_dout",  32'(dout), 32'h00);
        checkOutput("reset_busy",  32'(busy), 32'd0);
        checkOutput("reset_ovf",   32'(ovf),  32'd0);
        checkOutput("reset_stb",   32'(stb),  32'd0);
        checkOutput("reset_up",    32'(ups),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] addr 0x23 data 0x41 -> slot 3 mult");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h23);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h41);
        checkOutput("w23_busy", 32'(busy), 32'd1);
        checkOutput("w23_dout", 32'(dout), 32'h41);
        checkOutput("w23_up",   32'(ups),  32'b10000);
        checkOutput("w23_stb_early", 32'(stb), 32'd0);
        premature = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
            if (expSlot != 3 && stb != 3'b000) premature++;
        end
        checkOutput("w23_slot",  32'(slot), 32'(expSlot));
        checkOutput("w23_pre",   32'(premature), 32'd0);
        checkOutput("w23_stb",   32'(stb),  32'b111);
        checkOutput("w23_upfire", 32'(ups), 32'b10000);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("w23_clr_busy", 32'(busy), 32'd0);
        checkOutput("w23_clr_stb",  32'(stb),  32'd0);
        checkOutput("w23_clr_up",   32'(ups),  32'd0);

        $display("[TB] addr 0x55 data 0x3F -> slot 17 ksl_tl");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h55);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h3F);
        premature = 0;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
            if (expSlot != 17 && stb != 3'b000) premature++;
        end
        checkOutput("w55_slot", 32'(slot), 32'd17);
        checkOutput("w55_pre",  32'(premature), 32'd0);
        checkOutput("w55_stb",  32'(stb),  32'b111);
        checkOutput("w55_up",   32'(ups),  32'b01000);
        checkOutput("w55_dout", 32'(dout), 32'h3F);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("w55_clr_busy", 32'(busy), 32'd0);

        $display("[TB] addr 0x20 written with cen high -> waits for slot 0");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h20);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h5A);
        checkOutput("w20_slot", 32'(slot), 32'd2);
        checkOutput("w20_busy", 32'(busy), 32'd1);
        premature = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
            if (expSlot != 0 && stb != 3'b000) premature++;
        end
        checkOutput("w20_wrap", 32'(slot), 32'd0);
        checkOutput("w20_pre",  32'(premature), 32'd0);
        checkOutput("w20_stb",  32'(stb), 32'b111);
        checkOutput("w20_up",   32'(ups), 32'b10000);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("w20_clr_busy", 32'(busy), 32'd0);

        $display("[TB] invalid offset 0x26 and non-operator 0xA0");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h26);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h77);
        checkOutput("w26_busy", 32'(busy), 32'd0);
        checkOutput("w26_up",   32'(ups),  32'd0);
        premature = 0;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
            if (stb != 3'b000 || busy) premature++;
        end
        checkOutput("w26_quiet", 32'(premature), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hA0);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h12);
        checkOutput("wA0_busy", 32'(busy), 32'd0);
        checkOutput("wA0_up",   32'(ups),  32'd0);
        checkOutput("wA0_stb",  32'(stb),  32'd0);

        $display("[TB] overflow on data write while busy");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h21);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h11);
        checkOutput("ovf_busy", 32'(busy), 32'd1);
        checkOutput("ovf_pre",  32'(ovf),  32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h99);
        checkOutput("ovf_set",  32'(ovf),  32'd1);
        checkOutput("ovf_dout", 32'(dout), 32'h11);
        checkOutput("ovf_hold", 32'(busy), 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        end
        checkOutput("ovf_drain", 32'(busy), 32'd0);
        checkOutput("ovf_sticky", 32'(ovf), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h22);
        checkOutput("ovf_clear", 32'(ovf),  32'd0);
        checkOutput("ovf_newd",  32'(dout), 32'h22);
        checkOutput("ovf_rearm", 32'(busy), 32'd1);

        $display("[TB] reset while armed");
        @(negedge clk);
        rst = 1'b1;
        cen = 1'b0;
        wr  = 1'b0;
        #1;
        expSlot = 0;
        checkOutput("rst_slot", 32'(slot), 32'd0);
        checkOutput("rst_dout", 32'(dout), 32'h00);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ovf",  32'(ovf),  32'd0);
        checkOutput("rst_stb",  32'(stb),  32'd0);
        checkOutput("rst_up",   32'(ups),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        premature = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
            if (stb != 3'b000 || busy) premature++;
        end
        checkOutput("rst_nostb", 32'(premature), 32'd0);

        $display("[TB] offsets II=1 IV=17, addr 0x40");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h40);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h01);
        checkOutput("off_busy", 32'(busy2), 32'd1);
        checkOutput("off_up",   32'(up_ksl_tl2), 32'd1);
        cntI = 0; cntII = 0; cntIV = 0;
        slotI = -1; slotII = -1; slotIV = -1;
        busyAt1 = 1'b0;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
            if (stb2[2]) begin cntI++;  slotI  = expSlot; end
            if (stb2[1]) begin cntII++; slotII = expSlot; end
            if (stb2[0]) begin cntIV++; slotIV = expSlot; end
            if (expSlot == 1) busyAt1 = busy2;
        end
        checkOutput("off_slotI",  32'(slotI),  32'd0);
        checkOutput("off_slotII", 32'(slotII), 32'd1);
        checkOutput("off_slotIV", 32'(slotIV), 32'd17);
        checkOutput("off_cntI",   32'(cntI),   32'd1);
        checkOutput("off_cntII",  32'(cntII),  32'd1);
        checkOutput("off_cntIV",  32'(cntIV),  32'd1);
        checkOutput("off_busy1",  32'(busyAt1), 32'd1);
        checkOutput("off_done",   32'(busy2),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
